// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller and its datapath.
// The slave modport is the controller side; the master modport is the datapath side.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Op;
    logic             hold;
    logic             mem_ready;
    logic             PCWriteCond;
    logic             PCWriteCondN;
    logic             PCWrite;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             IRWrite;
    logic             ALUSrcA;
    logic             RegWrite;
    logic             RegDst;
    logic             illegal_op;
    logic [1:0]       PCSource;
    logic [2:0]       ALUOp;
    logic [1:0]       ALUSrcB;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output Op, hold, mem_ready,
        input  PCWriteCond, PCWriteCondN, PCWrite, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op,
               PCSource, ALUOp, ALUSrcB, state, instr_count
    );

    modport slave (
        input  Op, hold, mem_ready,
        output PCWriteCond, PCWriteCondN, PCWrite, IorD, MemRead, MemWrite,
               MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op,
               PCSource, ALUOp, ALUSrcB, state, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore-style multicycle MIPS controller with hold freeze, optional memory
// wait states, illegal-opcode trap and a retired-instruction counter.
module multicycle_control #(
    parameter int         MEM_WAIT = 0,
    parameter int         TRAP_EN  = 1,
    parameter int         IMM_EN   = 1,
    parameter int         BNE_EN   = 1,
    parameter logic [5:0] LW_OP    = 6'b100011,
    parameter logic [5:0] SW_OP    = 6'b101011,
    parameter int         CNT_W    = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADDR = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        RWB     = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        IEXEC   = 4'd10,
        IWB     = 4'd11,
        TRAP    = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q;
    logic             rdy, retire;
    logic             pc_write_cond, pc_write_cond_n, pc_write, iord;
    logic             mem_read, mem_write, mem_to_reg, ir_write;
    logic             alu_src_a, reg_write, reg_dst, illegal;
    logic [1:0]       pc_source, alu_src_b;
    logic [2:0]       alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_write_cond   = 1'b0;
        pc_write_cond_n = 1'b0;
        pc_write        = 1'b0;
        iord            = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_to_reg      = 1'b0;
        ir_write        = 1'b0;
        alu_src_a       = 1'b0;
        reg_write       = 1'b0;
        reg_dst         = 1'b0;
        illegal         = 1'b0;
        pc_source       = 2'b00;
        alu_src_b       = 2'b00;
        alu_op          = 3'b000;
        rdy             = (MEM_WAIT == 0) || bus.mem_ready;
        retire          = 1'b0;

        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = rdy;
                pc_write  = rdy;
                if (rdy) state_d = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if (bus.Op == 6'd0)
                    state_d = EXEC;
                else if (bus.Op == LW_OP || bus.Op == SW_OP)
                    state_d = MEMADDR;
                else if (bus.Op == 6'd4 || (bus.Op == 6'd5 && BNE_EN != 0))
                    state_d = BRANCH;
                else if (bus.Op == 6'd2)
                    state_d = JUMP;
                else if (IMM_EN != 0 && (bus.Op == 6'd8 || bus.Op == 6'd12 || bus.Op == 6'd13))
                    state_d = IEXEC;
                else
                    state_d = (TRAP_EN != 0) ? TRAP : FETCH;
            end
            MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.Op == LW_OP) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (rdy) state_d = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (rdy) state_d = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                state_d   = RWB;
            end
            RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 3'b001;
                pc_source       = 2'b01;
                pc_write_cond   = (bus.Op == 6'd4);
                pc_write_cond_n = (bus.Op == 6'd5);
                state_d         = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = FETCH;
            end
            IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (bus.Op)
                    6'd8:    alu_op = 3'b100;
                    6'd12:   alu_op = 3'b101;
                    6'd13:   alu_op = 3'b110;
                    default: alu_op = 3'b000;
                endcase
                state_d = IWB;
            end
            IWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
                illegal = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase

        // Hold freezes the state and every strobe; mux selects stay as decoded.
        if (bus.hold) begin
            state_d         = state_q;
            pc_write        = 1'b0;
            pc_write_cond   = 1'b0;
            pc_write_cond_n = 1'b0;
            ir_write        = 1'b0;
            mem_read        = 1'b0;
            mem_write       = 1'b0;
            reg_write       = 1'b0;
            illegal         = 1'b0;
        end

        if (state_d == FETCH && !bus.hold) begin
            case (state_q)
                MEMWB, MEMWR, RWB, BRANCH, JUMP, IWB, TRAP: retire = 1'b1;
                default:                                    retire = 1'b0;
            endcase
        end
    end

    // Outputs are gated by rst_n so they drop immediately, not at the next edge.
    assign bus.PCWriteCond  = rst_n & pc_write_cond;
    assign bus.PCWriteCondN = rst_n & pc_write_cond_n;
    assign bus.PCWrite      = rst_n & pc_write;
    assign bus.IorD         = rst_n & iord;
    assign bus.MemRead      = rst_n & mem_read;
    assign bus.MemWrite     = rst_n & mem_write;
    assign bus.MemtoReg     = rst_n & mem_to_reg;
    assign bus.IRWrite      = rst_n & ir_write;
    assign bus.ALUSrcA      = rst_n & alu_src_a;
    assign bus.RegWrite     = rst_n & reg_write;
    assign bus.RegDst       = rst_n & reg_dst;
    assign bus.illegal_op   = rst_n & illegal;
    assign bus.PCSource     = rst_n ? pc_source : 2'b00;
    assign bus.ALUOp        = rst_n ? alu_op : 3'b000;
    assign bus.ALUSrcB      = rst_n ? alu_src_b : 2'b00;
    assign bus.state        = state_q;
    assign bus.instr_count  = count_q;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (all state changes on rising edge); rst_n input 1 (asynchronous, active-low).
REQ-002 SHALL have parameter MEM_WAIT, default 0, meaning 1 = memory states wait for mem_ready and 0 = mem_ready ignored (treated as 1).
REQ-003 SHALL have parameter TRAP_EN, default 1, meaning 1 = illegal opcode goes through TRAP.
REQ-004 SHALL have parameters IMM_EN, default 1 (addi/andi/ori decoded), and BNE_EN, default 1 (bne decoded).
REQ-005 SHALL have parameters LW_OP, default 6'b100011 (load opcode), and SW_OP, default 6'b101011 (store opcode).
REQ-006 SHALL have parameter CNT_W, default 16, meaning instr_count width.
REQ-007 SHALL have inputs Op (6, instruction opcode), hold (1, freeze request) and mem_ready (1, memory handshake).
REQ-008 SHALL have 1-bit outputs PCWriteCond, PCWriteCondN, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst and illegal_op.
REQ-009 SHALL have outputs PCSource (2), ALUOp (3), ALUSrcB (2), state (4, debug) and instr_count (CNT_W, retired instructions).

Function
REQ-010 SHALL be a Moore FSM: outputs decoded only from the state register, hold and mem_ready; any output not listed for a state is 0.
REQ-011 SHALL implement FETCH(0): MemRead=1, ALUSrcB=01; IRWrite=PCWrite=mem_ready; mem_ready=1 -> DECODE, else stay in FETCH.
REQ-012 SHALL implement DECODE(1): ALUSrcB=11, ALUOp=000.
REQ-013 SHALL decode DECODE transitions: Op=0 -> EXEC; LW_OP/SW_OP -> MEMADDR; 4 -> BRANCH; 5 -> BRANCH if BNE_EN; 2 -> JUMP; 8/12/13 -> IEXEC if IMM_EN.
REQ-014 SHALL send any other Op from DECODE to TRAP if TRAP_EN, else to FETCH.
REQ-015 SHALL implement MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=000; -> MEMRD on LW_OP, MEMWR on SW_OP.
REQ-016 SHALL implement MEMRD(3): MemRead=1, IorD=1; mem_ready=1 -> MEMWB.
REQ-017 SHALL implement MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
REQ-018 SHALL implement MEMWR(5): MemWrite=1, IorD=1; -> FETCH when mem_ready=1, else remain with MemWrite held.
REQ-019 SHALL implement EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=010; -> RWB.
REQ-020 SHALL implement RWB(7): RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-021 SHALL implement BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCWriteCond=(Op==4), PCWriteCondN=(Op==5); -> FETCH.
REQ-022 SHALL implement JUMP(9): PCWrite=1, PCSource=10; -> FETCH.
REQ-023 SHALL implement IEXEC(10): ALUSrcA=1, ALUSrcB=10; ALUOp=100 for addi(8), 101 for andi(12), 110 for ori(13); -> IWB.
REQ-024 SHALL implement IWB(11): RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH.
REQ-025 SHALL implement TRAP(12): illegal_op=1 for exactly one cycle; -> FETCH.
REQ-026 SHALL treat codes 13-15 as unreachable and recover them to FETCH on the next edge with all outputs 0.
REQ-027 SHALL, while hold=1 (priority over mem_ready): keep state unchanged and force PCWrite, PCWriteCond, PCWriteCondN, IRWrite, MemRead, MemWrite, RegWrite and illegal_op to 0; mux selects keep their state values.
REQ-028 SHALL, when hold is released, resume the held state with full outputs.
REQ-029 SHALL keep Op stable in the external IR from DECODE to completion; the block stores no opcode.
REQ-030 SHALL increment instr_count by 1 on every non-held transition into FETCH from MEMWB, MEMWR, RWB, BRANCH, JUMP, IWB or TRAP, wrapping from all-ones to 0.
REQ-031 SHALL take 3 cycles for jump/branch, 4 for R-type/immediate/sw and 5 for lw (MEM_WAIT=0, no hold); each memory wait cycle adds 1.
REQ-032 SHALL output the current state code on state.

Reset
REQ-033 SHALL, with rst_n=0, immediately force state=FETCH, instr_count=0 and all outputs 0, regardless of clk, including mid-instruction.
REQ-034 SHALL, after rst_n rises, start in FETCH with FETCH outputs at the first rising edge; no partial instruction is resumed.

Verification
REQ-035 SHALL verify R-type: Op=0, MEM_WAIT=0 -> states 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7; instr_count 0->1.
REQ-036 SHALL verify lw with waits: MEM_WAIT=1, Op=LW_OP, mem_ready low 2 cycles in MEMRD -> MEMRD lasts 3 cycles with MemRead=1, IorD=1; then MEMWB with MemtoReg=1.
REQ-037 SHALL verify bne: Op=5 -> in BRANCH PCWriteCondN=1, PCWriteCond=0, PCSource=01; with BNE_EN=0 -> TRAP, illegal_op one-cycle pulse.
REQ-038 SHALL verify hold: hold=1 for 3 cycles during MEMWR -> state stays 5, MemWrite=0; after release MemWrite=1 one cycle; instr_count increments once.
REQ-039 SHALL verify reset and wrap: rst_n low during IEXEC -> all outputs 0 asynchronously, state=0 at release; with CNT_W=2, 4 retirements -> instr_count returns to 0.
